// File: rtl/decrypt_2blocks_128a.sv
// Ascon-128a decryption core for one 128-bit AD block and one 128-bit
// ciphertext block. Two permutation rounds are applied per clock.
// The recomputed tag is compared with T, and the plaintext is released only
// when the two tags match.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   one-cycle request, sampled only in IDLE
//   SK, N   key and nonce
//   A       associated-data block
//   C       ciphertext block
//   T       received tag
//   busy    high while an operation is in flight
//   done    one-cycle pulse; P and tag_ok are valid from this cycle
//   tag_ok  computed tag equals T
//   P       recovered plaintext; forced to zero on a tag mismatch
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// INIT  | p^12 over {IV,SK,N}; the last edge keys the state and absorbs A
// AD    | p^8 after A; the last edge decrypts C and keys the state for finalisation
// FIN   | p^12 finalisation; the last edge compares the tag and drives the outputs
module decrypt_2blocks_128a #(
    parameter logic [63:0] IV = 64'h80800c0800000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] SK,
    input  logic [127:0] N,
    input  logic [127:0] A,
    input  logic [127:0] C,
    input  logic [127:0] T,
    output logic         busy,
    output logic         done,
    output logic         tag_ok,
    output logic [127:0] P
);

    typedef enum logic [1:0] {IDLE, INIT, AD, FIN} state_t;

    state_t         fsm;
    logic [319:0]   s;
    logic [3:0]     rnd;
    logic [127:0]   sk_q;
    logic [127:0]   a_q;
    logic [127:0]   c_q;
    logic [127:0]   t_q;
    logic [127:0]   p_raw;

    logic [319:0]   perm_in;
    logic [319:0]   perm_out;
    logic [3:0]     idx;
    logic [127:0]   tag_calc;
    logic           last;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round with round constant index i (constant = {~i, i}).
    function automatic logic [319:0] ascon_round(input logic [319:0] st, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = st;
        x2 = x2 ^ {56'd0, 4'hf - i, i};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // rnd reaches 12 once the current permutation is exhausted; that edge
    // performs the phase transition and starts the next permutation.
    assign last = (rnd == 4'd12);

    always_comb begin
        perm_in = s;
        idx     = rnd;
        if (last) begin
            if (fsm == INIT) begin
                perm_in = s ^ {192'd0, sk_q} ^ {a_q, 192'd0};
                idx     = 4'd4;
            end else if (fsm == AD) begin
                perm_in = {c_q, s[191:64] ^ sk_q, s[63:1], ~s[0]};
                idx     = 4'd0;
            end
        end
    end

    assign perm_out = ascon_round(ascon_round(perm_in, idx), idx + 4'd1);
    assign tag_calc = s[127:0] ^ sk_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm    <= IDLE;
            s      <= '0;
            rnd    <= '0;
            sk_q   <= '0;
            a_q    <= '0;
            c_q    <= '0;
            t_q    <= '0;
            p_raw  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            tag_ok <= 1'b0;
            P      <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        sk_q <= SK;
                        a_q  <= A;
                        c_q  <= C;
                        t_q  <= T;
                        s    <= {IV, SK, N};
                        rnd  <= 4'd0;
                        busy <= 1'b1;
                        fsm  <= INIT;
                    end
                end
                INIT: begin
                    s   <= perm_out;
                    rnd <= idx + 4'd2;
                    if (last) fsm <= AD;
                end
                AD: begin
                    s   <= perm_out;
                    rnd <= idx + 4'd2;
                    if (last) begin
                        p_raw <= s[319:192] ^ c_q;
                        fsm   <= FIN;
                    end
                end
                FIN: begin
                    if (last) begin
                        tag_ok <= (tag_calc == t_q);
                        P      <= (tag_calc == t_q) ? p_raw : 128'd0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        fsm    <= IDLE;
                    end else begin
                        s   <= perm_out;
                        rnd <= idx + 4'd2;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_2blocks_128a.sv
module tb_decrypt_2blocks_128a;

    localparam logic [63:0]  IV  = 64'h80800c0800000000;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [4:0] SBOX [0:31] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23};

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] SK, N, A, C, T;
    logic         busy, done, tag_ok;
    logic [127:0] P;

    int checks = 0;
    int errors = 0;

    logic [127:0] c1, t1, c2, t2;

    decrypt_2blocks_128a dut (
        .clk(clk), .reset(reset), .start(start),
        .SK(SK), .N(N), .A(A), .C(C), .T(T),
        .busy(busy), .done(done), .tag_ok(tag_ok), .P(P));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: table-driven S-box per bit column, used only to
    // produce ciphertext/tag stimulus from a known plaintext.
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] m_round(input logic [319:0] st, input int r);
        logic [63:0] x [5];
        logic [4:0]  v;
        logic [7:0]  rc;
        for (int i = 0; i < 5; i++) x[i] = st[319 - 64*i -: 64];
        rc = 8'((15 - r) * 16 + r);
        x[2][7:0] = x[2][7:0] ^ rc;
        for (int b = 0; b < 64; b++) begin
            v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            v = SBOX[v];
            {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = v;
        end
        x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] st, input int nr);
        logic [319:0] r;
        r = st;
        for (int i = 12 - nr; i < 12; i++) r = m_round(r, i);
        return r;
    endfunction

    task automatic encrypt(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a,
                           input logic [127:0] pt, output logic [127:0] c, output logic [127:0] t);
        logic [319:0] st;
        st = m_perm({IV, k, n}, 12);
        st[127:0]   = st[127:0] ^ k;
        st[319:192] = st[319:192] ^ a;
        st = m_perm(st, 8);
        st[0] = ~st[0];
        c = st[319:192] ^ pt;
        st[319:192] = c;
        st[191:64]  = st[191:64] ^ k;
        st = m_perm(st, 12);
        t = st[127:0] ^ k;
    endtask

    // Starts one operation and watches 40 edges after the start edge.
    // lat is the edge index (start edge = 0) after which done was first seen.
    task automatic do_run(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a,
                          input logic [127:0] c, input logic [127:0] t, input bit poke,
                          output int lat, output int busy_n, output int ndone,
                          output logic [127:0] p_at, output logic ok_at);
        SK = k; N = n; A = a; C = c; T = t;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_n = 0; ndone = 0; p_at = 'x; ok_at = 1'bx;
        for (int e = 1; e <= 40; e++) begin
            if (busy) busy_n++;
            if (poke && e == 1) begin
                SK = ~k; N = ~n; A = ~a; C = ~c; T = ~t;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = e; p_at = P; ok_at = tag_ok; end
            end
            start = poke && (e == 2 || e == 8);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (tag_ok !== 1'b0) begin errors++; $display("FAIL reset_tag_ok got %b want 0", tag_ok); end
        checks++; if (P !== 128'd0)   begin errors++; $display("FAIL reset_P got %h want 0", P); end
    endtask

    task automatic test_vector1;
        int lat, bn, nd; logic [127:0] p; logic ok;
        do_run(K1, K1, K1, c1, t1, 1'b0, lat, bn, nd, p, ok);
        checks++; if (lat !== 17) begin errors++; $display("FAIL v1_latency got %0d want 17", lat); end
        checks++; if (bn !== 17)  begin errors++; $display("FAIL v1_busy_cycles got %0d want 17", bn); end
        checks++; if (nd !== 1)   begin errors++; $display("FAIL v1_done_count got %0d want 1", nd); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL v1_tag_ok got %b want 1", ok); end
        checks++; if (p !== PT1)  begin errors++; $display("FAIL v1_P got %h want %h", p, PT1); end
        checks++; if (P !== PT1)  begin errors++; $display("FAIL v1_P_hold got %h want %h", P, PT1); end
    endtask

    task automatic test_bad_tag;
        int lat, bn, nd; logic [127:0] p; logic ok;
        do_run(K1, K1, K1, c1, t1 ^ 128'd1, 1'b0, lat, bn, nd, p, ok);
        checks++; if (lat !== 17)  begin errors++; $display("FAIL badT_latency got %0d want 17", lat); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL badT_tag_ok got %b want 0", ok); end
        checks++; if (p !== 128'd0) begin errors++; $display("FAIL badT_P got %h want 0", p); end
    endtask

    task automatic test_bit_flips;
        int lat, bn, nd; logic [127:0] p; logic ok;
        do_run(K1, K1, K1, c1 ^ {1'b1, 127'd0}, t1, 1'b0, lat, bn, nd, p, ok);
        checks++; if (ok !== 1'b0)  begin errors++; $display("FAIL flipC_tag_ok got %b want 0", ok); end
        checks++; if (p !== 128'd0) begin errors++; $display("FAIL flipC_P got %h want 0", p); end
        do_run(K1, K1, K1 ^ (128'd1 << 64), c1, t1, 1'b0, lat, bn, nd, p, ok);
        checks++; if (ok !== 1'b0)  begin errors++; $display("FAIL flipA_tag_ok got %b want 0", ok); end
        checks++; if (p !== 128'd0) begin errors++; $display("FAIL flipA_P got %h want 0", p); end
        do_run(K1, K1 ^ 128'd32, K1, c1, t1, 1'b0, lat, bn, nd, p, ok);
        checks++; if (ok !== 1'b0)  begin errors++; $display("FAIL flipN_tag_ok got %b want 0", ok); end
        do_run(K1 ^ (128'd1 << 100), K1, K1, c1, t1, 1'b0, lat, bn, nd, p, ok);
        checks++; if (ok !== 1'b0)  begin errors++; $display("FAIL flipSK_tag_ok got %b want 0", ok); end
    endtask

    task automatic test_start_ignored;
        int lat, bn, nd; logic [127:0] p; logic ok;
        do_run(K1, K1, K1, c1, t1, 1'b1, lat, bn, nd, p, ok);
        checks++; if (nd !== 1)    begin errors++; $display("FAIL busy_start_done_count got %0d want 1", nd); end
        checks++; if (lat !== 17)  begin errors++; $display("FAIL busy_start_latency got %0d want 17", lat); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busy_start_tag_ok got %b want 1", ok); end
        checks++; if (p !== PT1)   begin errors++; $display("FAIL busy_start_P got %h want %h", p, PT1); end
    endtask

    task automatic test_reset_abort;
        int lat, bn, nd, spurious; logic [127:0] p; logic ok;
        SK = K1; N = K1; A = K1; C = c1; T = t1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (tag_ok !== 1'b0) begin errors++; $display("FAIL abort_tag_ok got %b want 0", tag_ok); end
        checks++; if (P !== 128'd0)    begin errors++; $display("FAIL abort_P got %h want 0", P); end
        spurious = 0;
        repeat (2) begin @(posedge clk); #1; if (done) spurious++; end
        reset = 1'b1;
        repeat (30) begin @(posedge clk); #1; if (done) spurious++; end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_spurious_done got %0d want 0", spurious); end
        do_run(K1, K1, K1, c1, t1, 1'b0, lat, bn, nd, p, ok);
        checks++; if (lat !== 17)  begin errors++; $display("FAIL after_abort_latency got %0d want 17", lat); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL after_abort_tag_ok got %b want 1", ok); end
        checks++; if (p !== PT1)   begin errors++; $display("FAIL after_abort_P got %h want %h", p, PT1); end
    endtask

    task automatic test_back_to_back;
        int d_edge [2]; logic [127:0] d_p [2]; logic d_ok [2]; int nd;
        nd = 0;
        d_edge[0] = -1; d_edge[1] = -1;
        SK = K1; N = K1; A = K1; C = c1; T = t1;
        start = 1'b1;
        @(posedge clk); #1;
        SK = '0; N = '0; A = '0; C = c2; T = t2;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd < 2) begin d_edge[nd] = e; d_p[nd] = P; d_ok[nd] = tag_ok; end
                nd++;
            end
            if (e == 18) start = 1'b0;
        end
        start = 1'b0;
        checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", nd); end
        checks++; if (d_edge[0] !== 17) begin errors++; $display("FAIL b2b_first_edge got %0d want 17", d_edge[0]); end
        checks++; if (d_edge[1] !== 35) begin errors++; $display("FAIL b2b_second_edge got %0d want 35", d_edge[1]); end
        if (nd >= 2) begin
            checks++; if (d_ok[0] !== 1'b1) begin errors++; $display("FAIL b2b_tag_ok1 got %b want 1", d_ok[0]); end
            checks++; if (d_p[0] !== PT1)   begin errors++; $display("FAIL b2b_P1 got %h want %h", d_p[0], PT1); end
            checks++; if (d_ok[1] !== 1'b1) begin errors++; $display("FAIL b2b_tag_ok2 got %b want 1", d_ok[1]); end
            checks++; if (d_p[1] !== PT2)   begin errors++; $display("FAIL b2b_P2 got %h want %h", d_p[1], PT2); end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        SK = '0; N = '0; A = '0; C = '0; T = '0;
        encrypt(K1, K1, K1, PT1, c1, t1);
        encrypt(128'd0, 128'd0, 128'd0, PT2, c2, t2);
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        test_vector1;
        test_bad_tag;
        test_bit_flips;
        test_start_ignored;
        test_reset_abort;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
